instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Write-side companion to the instruction ROM. It receives a byte stream and builds a program image from it: a 16-bit word count, 32-bit instructions MSB-first, then an XOR checksum byte. Each completed word is written into the instruction memory through a single-port write interface. While loading, it holds the processor core in reset; it reports done or error when the image ends.

## Interface
Parameters:
- ADDR_WIDTH, 10, instruction memory address width (matches the 10-bit fetch address)
- DEPTH, 69, number of implemented instruction words; a count above this is rejected

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a new load; sampled only in IDLE, DONE, ERROR
- in_valid  in  1  byte available on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word
- mem_addr  out  ADDR_WIDTH  write address
- mem_wdata  out  32  instruction word
- cpu_hold  out  1  holds the core in reset while loading
- busy  out  1  load in progress
- done  out  1  sticky; image loaded and checksum matched
- error  out  1  sticky; count above DEPTH or checksum mismatch

## Operation
- States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
- A byte is accepted when `in_valid & in_ready`. in_ready=1 only in LEN_HI, LEN_LO, DATA and CHECK.
- IDLE/DONE/ERROR + start:
  - go to LEN_HI
  - clear done, error, checksum, address and byte index
- LEN_HI: accept count[15:8] -> LEN_LO.
- LEN_LO: accept count[7:0]. Then:
  - count > DEPTH -> ERROR
  - count == 0 -> CHECK
  - otherwise -> DATA
- DATA:
  - bytes shift into a 32-bit packer, MSB first
  - on the 4th byte: issue a write to mem_addr, increment the address, decrement the remaining count
  - when remaining reaches 0 -> CHECK
- CHECK: accept one byte.
  - equal to the running checksum -> DONE
  - else -> ERROR
- Running checksum: XOR of every accepted byte from LEN_HI through the last DATA byte. The check byte itself is excluded.
- No rollback on error. Words already written stay in memory; error marks the image invalid.
- cpu_hold = busy; busy = 1 in LEN_HI, LEN_LO, DATA, CHECK.
- start while busy is ignored.
- Memory address wraps never: count ≤ DEPTH guarantees max address DEPTH-1.

## Timing
- Reset values:
  - state IDLE
  - in_ready, mem_we, cpu_hold, busy, done, error = 0
  - mem_addr = 0, mem_wdata = 0
- Reset mid-load:
  - everything returns to the reset values on the next edge
  - a write pending in the same cycle is suppressed
- start -> in_ready=1 on the following cycle.
- Write latency: mem_we, mem_addr and mem_wdata are registered and valid the cycle after the 4th byte of a word is accepted.
  - mem_addr holds the address of that word during the pulse
  - the counter advances afterwards
- Throughput: one byte per cycle sustained; in_ready does not drop between words.
- done/error assert the cycle after the check byte (or the bad LEN_LO byte) is accepted. They hold until start or reset.
- cpu_hold deasserts in the same cycle done or error asserts.

## Structure
- Package loader_pkg holds:
  - the state enum
  - header length constant (2)
  - bytes-per-word constant (4)
  - default DEPTH
- One sub-module, byte_packer:
  - 8→32 shift register with a 2-bit byte index
  - outputs word_valid on the 4th byte
  - synchronous clear
- FSM, counters and checksum live in instr_mem_loader.

## Test plan
- Count 2 (00 02), words 3400001B and 3400001C, correct checksum:
  - exactly two mem_we pulses, at addr 0 and 1, with those data
  - done=1, error=0, cpu_hold drops
- Same image with the checksum byte XOR 0x01:
  - both words still written
  - error=1, done=0
- Count 70 (00 46):
  - error asserts the cycle after the LEN_LO byte
  - no mem_we
  - in_ready=0 afterwards
- Count 0 followed by checksum 00: done=1, no writes.
- Count 69 streamed with in_valid toggled randomly:
  - 69 writes, addresses 0..68 in order
  - last address 68, done=1
- reset asserted after 5 data bytes of a 3-word load:
  - all outputs at reset values next cycle
  - a new start reloads from addr 0 correctly

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// State encoding, header/word framing sizes and default memory depth.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEFAULT_DEPTH  = 69;

endpackage

// File: rtl/byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words.
// Ports: clock, reset, clear, en, byte_in -> word, word_valid (on 4th byte).
module byte_packer
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx;
    logic [23:0] sh;

    // The completed word is presented combinationally alongside the
    // 4th byte so the loader can register it into the write port.
    assign word       = {sh, byte_in};
    assign word_valid = en && (idx == IDX_LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            idx <= 2'd0;
            sh  <= 24'd0;
        end else if (en) begin
            idx <= idx + 2'd1;
            sh  <= {sh[15:0], byte_in};
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program image (count, MSB-first words, XOR checksum) into IMEM.
// Ports: clock, reset, start, in_valid/in_data/in_ready, mem_we/addr/wdata, cpu_hold, busy, done, error.
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t state, state_n;

    logic [7:0]            len_hi;
    logic [7:0]            csum;
    logic [15:0]           rem;
    logic [15:0]           count;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  accept;
    logic                  idle_like;
    logic                  load_start;
    logic                  pk_en;
    logic                  word_valid;
    logic [31:0]           word;

    assign busy = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                  (state == S_DATA)   || (state == S_CHECK);

    assign in_ready = busy;
    assign cpu_hold = busy;
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERROR);

    assign idle_like  = (state == S_IDLE) || (state == S_DONE) ||
                        (state == S_ERROR);
    assign load_start = idle_like && start;
    assign accept     = in_valid && in_ready;
    assign count      = {len_hi, in_data};
    assign pk_en      = accept && (state == S_DATA);

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (load_start),
        .en         (pk_en),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_n = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) state_n = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    if (count > DEPTH_W)
                        state_n = S_ERROR;
                    else if (count == 16'd0)
                        state_n = S_CHECK;
                    else
                        state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (word_valid && rem == 16'd1) state_n = S_CHECK;
            end
            S_CHECK: begin
                if (accept)
                    state_n = (in_data == csum) ? S_DONE : S_ERROR;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // Write port is registered; reset wins over a write completing
    // in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_hi    <= 8'd0;
            csum      <= 8'd0;
            rem       <= 16'd0;
            waddr     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            mem_we <= 1'b0;
            if (load_start) begin
                csum     <= 8'd0;
                waddr    <= '0;
                mem_addr <= '0;
            end
            // Check byte itself is excluded from the running checksum.
            if (accept && state != S_CHECK)
                csum <= csum ^ in_data;
            if (accept && state == S_LEN_HI)
                len_hi <= in_data;
            if (accept && state == S_LEN_LO)
                rem <= count;
            if (word_valid) begin
                mem_we    <= 1'b1;
                mem_addr  <= waddr;
                mem_wdata <= word;
                waddr     <= waddr + ADDR_WIDTH'(1);
                rem       <= rem - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: model predicts writes and result.
// Monitor pops expected writes on each mem_we pulse.
module tb_instr_mem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 69;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  nwrites  = 0;

    instr_mem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        wr_t e;
        if (mem_we === 1'b1) begin
            nwrites++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual addr=%0d data=%h required no write",
                         mem_addr, mem_wdata);
            end else begin
                e = sb.pop_front();
                chk("write_addr", 32'(mem_addr), e.addr);
                chk("write_data", mem_wdata, e.data);
            end
        end
    end

    task automatic build(input int cnt, input logic [31:0] w[$],
                         input logic [7:0] flip, output logic [7:0] img[$]);
        logic [7:0] cs;
        img.delete();
        img.push_back(8'(cnt >> 8));
        img.push_back(8'(cnt));
        foreach (w[i]) begin
            img.push_back(w[i][31:24]);
            img.push_back(w[i][23:16]);
            img.push_back(w[i][15:8]);
            img.push_back(w[i][7:0]);
        end
        cs = 8'd0;
        foreach (img[i]) cs ^= img[i];
        img.push_back(cs ^ flip);
    endtask

    // Reference: parse the image, queue expected writes, predict outcome
    // and how many bytes the loader will consume.
    task automatic model(input logic [7:0] img[$], output int n,
                         output bit d, output bit e, output int nw);
        int         cnt;
        logic [7:0] cs;
        wr_t        x;
        cnt = int'(img[0]) * 256 + int'(img[1]);
        d  = 1'b0;
        e  = 1'b0;
        nw = 0;
        if (cnt > DEPTH) begin
            n = 2;
            e = 1'b1;
            return;
        end
        cs = 8'd0;
        for (int i = 0; i < 2 + 4 * cnt; i++) cs ^= img[i];
        for (int k = 0; k < cnt; k++) begin
            x.addr = k;
            x.data = {img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]};
            sb.push_back(x);
        end
        nw = cnt;
        n  = 3 + 4 * cnt;
        d  = (img[n-1] == cs);
        e  = !d;
    endtask

    task automatic send(input logic [7:0] img[$], input int n, input bit rnd);
        int i     = 0;
        int guard = 0;
        bit fire;
        while (i < n) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = img[i];
            @(negedge clock);
            fire = in_valid && in_ready;
            @(posedge clock);
            #1;
            if (fire) i++;
            guard++;
            if (guard > 20 * n + 100) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=%0d bytes required=%0d", i, n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("start_in_ready", 32'(in_ready), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_hold", 32'(cpu_hold), 1);
        chk("start_done", 32'(done), 0);
        chk("start_error", 32'(error), 0);
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_hold", 32'(cpu_hold), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
    endtask

    task automatic run_image(input logic [7:0] img[$], input bit rnd);
        int n;
        int nw;
        int base;
        bit d;
        bit e;
        model(img, n, d, e, nw);
        base = nwrites;
        do_start();
        send(img, n, rnd);
        chk("end_done", 32'(done), 32'(d));
        chk("end_error", 32'(error), 32'(e));
        chk("end_hold", 32'(cpu_hold), 0);
        chk("end_in_ready", 32'(in_ready), 0);
        @(posedge clock);
        #1;
        chk("sticky_done", 32'(done), 32'(d));
        chk("sticky_error", 32'(error), 32'(e));
        chk("pending_writes", sb.size(), 0);
        chk("write_count", nwrites - base, nw);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  img[$];
        logic [31:0] w[$];
        wr_t         x;
        int          cnt;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clock);
        #1;

        w = '{32'h3400001B, 32'h3400001C};
        build(2, w, 8'h00, img);
        run_image(img, 1'b0);

        build(2, w, 8'h01, img);
        run_image(img, 1'b0);

        w.delete();
        build(70, w, 8'h00, img);
        run_image(img, 1'b0);

        build(0, w, 8'h00, img);
        run_image(img, 1'b0);

        w.delete();
        for (int k = 0; k < DEPTH; k++) w.push_back($urandom);
        build(DEPTH, w, 8'h00, img);
        run_image(img, 1'b1);
        chk("last_addr", 32'(mem_addr), DEPTH - 1);

        // Abort a 3-word load after 5 data bytes; only word 0 lands.
        w = '{$urandom, $urandom, $urandom};
        build(3, w, 8'h00, img);
        x.addr = 0;
        x.data = w[0];
        sb.push_back(x);
        do_start();
        send(img, 7, 1'b0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_vals();
        reset = 1'b0;
        chk("abort_pending", sb.size(), 0);
        sb.delete();
        build(3, w, 8'h00, img);
        run_image(img, 1'b0);

        for (int t = 0; t < 6; t++) begin
            w.delete();
            cnt = $urandom_range(0, 8);
            for (int k = 0; k < cnt; k++) w.push_back($urandom);
            build(cnt, w, ($urandom_range(0, 2) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00, img);
            run_image(img, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
